// File: rtl/cmplx_mult_pkg.sv
// Shared definitions for the complex multiplier sequencer: FSM state encoding,
// partial-product indices and the lane-count legality check.
package cmplx_mult_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StIssue   = 3'd2,
        StDrain   = 3'd3,
        StCompute = 3'd4,
        StWaitRes = 3'd5
    } state_e;

    // Partial products: P0=re1*re2, P1=im1*im2, P2=re1*im2, P3=im1*re2
    localparam logic [1:0] ProdP0 = 2'd0;
    localparam logic [1:0] ProdP1 = 2'd1;
    localparam logic [1:0] ProdP2 = 2'd2;
    localparam logic [1:0] ProdP3 = 2'd3;

    function automatic bit num_mult_legal(input int unsigned n);
        return (n == 1) || (n == 2) || (n == 4);
    endfunction

endpackage

// File: rtl/cmplx_mult_ctrl_if.sv
// Operand/result handshake plus the datapath control bundle of the sequencer.
// master: operand source / result consumer / datapath side. slave: the sequencer.
interface cmplx_mult_ctrl_if #(
    parameter int unsigned NUM_MULT = 1
);
    logic                op_val;
    logic                op_conj;
    logic                res_ready;
    logic                op_ready;
    logic                res_val;
    logic [NUM_MULT-1:0] op_1_sel;
    logic [NUM_MULT-1:0] op_2_sel;
    logic                issue_en;
    logic                wr_en;
    logic [1:0]          wr_sel;
    logic                conj_sel;
    logic                compute_enable;

    modport master (
        output op_val, op_conj, res_ready,
        input  op_ready, res_val, op_1_sel, op_2_sel, issue_en, wr_en, wr_sel, conj_sel,
               compute_enable
    );

    modport slave (
        input  op_val, op_conj, res_ready,
        output op_ready, res_val, op_1_sel, op_2_sel, issue_en, wr_en, wr_sel, conj_sel,
               compute_enable
    );
endinterface

// File: rtl/mult_lat_delay.sv
// Delay line matching the multiplier pipeline: carries {valid, phase} MULT_LAT
// cycles so the partial-product write lands with the lane outputs.
module mult_lat_delay #(
    parameter int unsigned MULT_LAT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       in_valid,
    input  logic [1:0] in_phase,
    output logic       out_valid,
    output logic [1:0] out_phase
);

    if (MULT_LAT == 0) begin : g_wire
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, clr};
        assign out_valid   = in_valid;
        assign out_phase   = in_phase;
    end else begin : g_line
        logic [2:0] line_q [MULT_LAT];

        // Shift {valid, phase} one stage per cycle; clr empties every stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < MULT_LAT; i++) line_q[i] <= 3'b000;
            end else if (clr) begin
                for (int i = 0; i < MULT_LAT; i++) line_q[i] <= 3'b000;
            end else begin
                line_q[0] <= {in_valid, in_phase};
                for (int i = 1; i < MULT_LAT; i++) line_q[i] <= line_q[i-1];
            end
        end

        assign {out_valid, out_phase} = line_q[MULT_LAT-1];
    end

endmodule

// File: rtl/cmplx_mult_ctrl.sv
// Sequencer for (a+jb)*(c+jd): schedules the four partial products over
// NUM_MULT lanes, waits out the multiplier latency, strobes the final adder and
// holds the result until consumed. A new operand pair may be taken in the same
// cycle the current result is handed off.
module cmplx_mult_ctrl
    import cmplx_mult_pkg::*;
#(
    parameter int unsigned NUM_MULT = 1,
    parameter int unsigned MULT_LAT = 0
) (
    input logic               clk,
    input logic               rst,
    input logic               sw_rst,
    cmplx_mult_ctrl_if.slave  bus
);

    localparam int unsigned Phases    = 4 / NUM_MULT;
    localparam logic [1:0]  LastPhase = 2'(Phases - 1);

    if (!num_mult_legal(NUM_MULT)) begin : g_bad_num_mult
        $error("cmplx_mult_ctrl: NUM_MULT must be 1, 2 or 4");
    end
    if (MULT_LAT > 7) begin : g_bad_mult_lat
        $error("cmplx_mult_ctrl: MULT_LAT must be 0..7");
    end

    state_e              state_q;
    logic [1:0]          phase_q;
    logic                conj_q;
    logic                op_ready;
    logic                take_op;
    logic                issue;
    logic                dly_valid;
    logic [1:0]          dly_phase;
    logic [1:0]          prod;
    logic [NUM_MULT-1:0] op_1_sel;
    logic [NUM_MULT-1:0] op_2_sel;

    // Operand handshake; ready in WAIT_RES follows res_ready combinationally
    always_comb begin
        op_ready = ~sw_rst & ((state_q == StIdle) | ((state_q == StWaitRes) & bus.res_ready));
        take_op  = bus.op_val & op_ready;
        issue    = (state_q == StIssue);
    end

    // Main FSM with phase counter and conj mode latched on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            phase_q <= 2'd0;
            conj_q  <= 1'b0;
        end else if (sw_rst) begin
            state_q <= StIdle;
            phase_q <= 2'd0;
            conj_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (take_op) begin
                        state_q <= StLoad;
                        conj_q  <= bus.op_conj;
                    end
                end
                StLoad: begin
                    state_q <= StIssue;
                    phase_q <= 2'd0;
                end
                StIssue: begin
                    if (phase_q == LastPhase) begin
                        phase_q <= 2'd0;
                        state_q <= (MULT_LAT == 0) ? StCompute : StDrain;
                    end else begin
                        phase_q <= phase_q + 2'd1;
                    end
                end
                StDrain: begin
                    // Leave together with the write of the last phase's products
                    if (dly_valid && (dly_phase == LastPhase)) state_q <= StCompute;
                end
                StCompute: begin
                    state_q <= StWaitRes;
                end
                StWaitRes: begin
                    if (bus.res_ready) begin
                        if (take_op) begin
                            state_q <= StLoad;
                            conj_q  <= bus.op_conj;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    phase_q <= 2'd0;
                end
            endcase
        end
    end

    // Lane k in phase p handles product j = p*NUM_MULT + k
    always_comb begin
        op_1_sel = '0;
        op_2_sel = '0;
        prod     = ProdP0;
        if (issue) begin
            for (int k = 0; k < NUM_MULT; k++) begin
                prod        = 2'({30'd0, phase_q} * NUM_MULT + k);
                op_1_sel[k] = (prod == ProdP1) || (prod == ProdP3);
                op_2_sel[k] = (prod == ProdP1) || (prod == ProdP2);
            end
        end
    end

    // Phase is gated with issue so wr_sel reads 0 whenever wr_en is low
    mult_lat_delay #(
        .MULT_LAT (MULT_LAT)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .clr       (sw_rst),
        .in_valid  (issue),
        .in_phase  (issue ? phase_q : 2'd0),
        .out_valid (dly_valid),
        .out_phase (dly_phase)
    );

    assign bus.op_ready       = op_ready;
    assign bus.res_val        = (state_q == StWaitRes);
    assign bus.op_1_sel       = op_1_sel;
    assign bus.op_2_sel       = op_2_sel;
    assign bus.issue_en       = issue;
    assign bus.wr_en          = dly_valid;
    assign bus.wr_sel         = dly_phase;
    assign bus.conj_sel       = conj_q;
    assign bus.compute_enable = (state_q == StCompute);

endmodule

// File: tb/tb_cmplx_mult_ctrl.sv
// Bench for cmplx_mult_ctrl: four configurations share one stimulus stream.
// Each has a timeline model (cycles since acceptance) giving expected outputs.
// Output vector layout: [15] op_ready [14] res_val [13:10] op_1_sel [9:6] op_2_sel
// [5] issue_en [4] wr_en [3:2] wr_sel [1] conj_sel [0] compute_enable
module tb_cmplx_mult_ctrl;

    localparam int CfgNm  [4] = '{1, 4, 2, 1};
    localparam int CfgLat [4] = '{0, 3, 2, 4};
    localparam logic [15:0] RstVec = 16'h8000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sw_rst = 1'b0;
    logic op_val = 1'b0;
    logic op_conj = 1'b0;
    logic res_ready = 1'b0;

    logic [15:0] act_all [4];
    logic [15:0] exp_all [4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int Nm  = CfgNm[g];
        localparam int Lat = CfgLat[g];
        localparam int P   = 4 / Nm;

        cmplx_mult_ctrl_if #(.NUM_MULT(Nm)) bus ();

        assign bus.op_val    = op_val;
        assign bus.op_conj   = op_conj;
        assign bus.res_ready = res_ready;

        cmplx_mult_ctrl #(
            .NUM_MULT (Nm),
            .MULT_LAT (Lat)
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .sw_rst (sw_rst),
            .bus    (bus)
        );

        // Reference: t = cycles since acceptance (LOAD is t=1), -1 when idle
        int          t;
        logic        conj;
        logic        m_idle, m_issue, m_wr, m_comp, m_resv, m_ready;
        logic [3:0]  e_op1, e_op2;
        logic [1:0]  e_ws;
        logic [15:0] exp_v;

        always_comb begin
            m_idle  = (t < 0);
            m_issue = (t >= 2) && (t <= 1 + P);
            m_wr    = (t >= 2 + Lat) && (t <= 1 + P + Lat);
            m_comp  = (t == 2 + P + Lat);
            m_resv  = (t >= 3 + P + Lat);
            m_ready = ~sw_rst & (m_idle | (m_resv & res_ready));
            e_ws    = m_wr ? 2'(t - 2 - Lat) : 2'd0;
            e_op1   = 4'd0;
            e_op2   = 4'd0;
            for (int k = 0; k < Nm; k++) begin
                if (m_issue) begin
                    e_op1[k] = ((t - 2) * Nm + k == 1) || ((t - 2) * Nm + k == 3);
                    e_op2[k] = ((t - 2) * Nm + k == 1) || ((t - 2) * Nm + k == 2);
                end
            end
            exp_v = {m_ready, m_resv, e_op1, e_op2, m_issue, m_wr, e_ws, conj, m_comp};
        end

        always @(posedge clk or posedge rst) begin
            if (rst || sw_rst) begin
                t    <= -1;
                conj <= 1'b0;
            end else if (m_ready && op_val) begin
                t    <= 1;
                conj <= op_conj;
            end else if (m_resv && res_ready) begin
                t <= -1;
            end else if (t >= 1 && !m_resv) begin
                t <= t + 1;
            end
        end

        assign act_all[g] = {bus.op_ready, bus.res_val, 4'(bus.op_1_sel), 4'(bus.op_2_sel),
                             bus.issue_en, bus.wr_en, bus.wr_sel, bus.conj_sel,
                             bus.compute_enable};
        assign exp_all[g] = exp_v;
    end

    typedef struct packed {
        logic        v;
        logic        c;
        logic        r;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [15:0] pk(input logic ordy, input logic rv, input logic [3:0] o1,
                                       input logic [3:0] o2, input logic ie, input logic we,
                                       input logic [1:0] ws, input logic cj, input logic ce);
        return {ordy, rv, o1, o2, ie, we, ws, cj, ce};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 4; i++) chk($sformatf("model cfg%0d", i), act_all[i], exp_all[i]);
    endtask

    // One clock: drive after the edge, compare at the falling edge
    task automatic step(input logic v, input logic c, input logic r, input logic s);
        @(posedge clk);
        #1;
        op_val    = v;
        op_conj   = c;
        res_ready = r;
        sw_rst    = s;
        @(negedge clk);
        cyc++;
        check_model();
    endtask

    task automatic do_sw_rst();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sw_rst masks op_ready", 16'(act_all[0][15]), 16'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) chk($sformatf("after sw_rst cfg%0d", i), act_all[i], RstVec);
    endtask

    initial begin
        // NUM_MULT=1, MULT_LAT=0 single operation with conj, result taken at c8
        tbl[0] = '{1'b1, 1'b1, 1'b0, pk(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0)};
        tbl[1] = '{1'b0, 1'b0, 1'b0, pk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0)};
        tbl[2] = '{1'b0, 1'b0, 1'b0, pk(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0)};
        tbl[3] = '{1'b0, 1'b0, 1'b0, pk(1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0)};
        tbl[4] = '{1'b0, 1'b0, 1'b0, pk(1'b0, 1'b0, 4'd0, 4'd1, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0)};
        tbl[5] = '{1'b0, 1'b0, 1'b0, pk(1'b0, 1'b0, 4'd1, 4'd0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0)};
        tbl[6] = '{1'b0, 1'b0, 1'b0, pk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1)};
        tbl[7] = '{1'b0, 1'b0, 1'b0, pk(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0)};
        tbl[8] = '{1'b0, 1'b0, 1'b1, pk(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0)};
        tbl[9] = '{1'b0, 1'b0, 1'b0, pk(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0)};

        // Reset state
        repeat (3) @(negedge clk);
        check_model();
        for (int i = 0; i < 4; i++) chk($sformatf("reset cfg%0d", i), act_all[i], RstVec);
        rst = 1'b0;

        // Table-driven single operation on cfg0
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].r, 1'b0);
            chk($sformatf("table row %0d", i), act_all[0], tbl[i].exp);
        end

        // NUM_MULT=4, MULT_LAT=3: one issue cycle, write three cycles later
        do_sw_rst();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 7; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (c == 2) begin
                chk("nm4 op_1_sel", 16'(act_all[1][13:10]), 16'h000a);
                chk("nm4 op_2_sel", 16'(act_all[1][9:6]), 16'h0006);
            end
            chk($sformatf("nm4 issue_en c%0d", c), 16'(act_all[1][5]), (c == 2) ? 16'd1 : 16'd0);
            chk($sformatf("nm4 wr_en c%0d", c), 16'(act_all[1][4]), (c == 5) ? 16'd1 : 16'd0);
            chk($sformatf("nm4 compute c%0d", c), 16'(act_all[1][0]), (c == 6) ? 16'd1 : 16'd0);
            chk($sformatf("nm4 res_val c%0d", c), 16'(act_all[1][14]), (c == 7) ? 16'd1 : 16'd0);
        end

        // NUM_MULT=2, MULT_LAT=2: backpressure then back-to-back accept
        do_sw_rst();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 7; c <= 11; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("hold res_val c%0d", c), 16'(act_all[2][14]), 16'd1);
            chk($sformatf("hold op_ready c%0d", c), 16'(act_all[2][15]), 16'd0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("b2b op_ready", 16'(act_all[2][15]), 16'd1);
        chk("b2b res_val", 16'(act_all[2][14]), 16'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b load state", act_all[2],
            pk(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b issue", 16'(act_all[2][5]), 16'd1);

        // conj latched on accept, unaffected by op_conj/op_val activity afterwards
        do_sw_rst();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            step(1'(c % 2), 1'((c + 1) % 2), 1'b0, 1'b0);
            chk($sformatf("conj_sel held c%0d", c), 16'(act_all[0][1]), 16'd1);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("conj_sel at handshake", 16'(act_all[0][1]), 16'd1);
        chk("res_val at handshake", 16'(act_all[0][14]), 16'd1);

        // sw_rst in the middle of DRAIN on NUM_MULT=1, MULT_LAT=4
        do_sw_rst();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("drain first write", 16'(act_all[3][4:2]), 16'h0004);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sw_rst cycle op_ready", 16'(act_all[3][15]), 16'd0);
        for (int c = 8; c <= 12; c++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("no wr_en after sw_rst c%0d", c), 16'(act_all[3][4]), 16'd0);
        end
        chk("idle after sw_rst", act_all[3], RstVec);

        // Asynchronous reset in the middle of ISSUE
        do_sw_rst();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("issuing before rst", 16'(act_all[0][5]), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) chk($sformatf("async rst cfg%0d", i), act_all[i], RstVec);
        check_model();
        @(negedge clk);
        rst = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
